// File: rtl/robonaut_pkg.sv
// Shared types and constants for the return-address stack responder.
package robonaut_pkg;

    localparam int         WORD_W         = 32;
    localparam int         RA_W           = 64;
    localparam logic [9:0] SP_TOP_DEFAULT = 10'h3F9;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PUSH_LO  = 3'd1,
        PUSH_HI  = 3'd2,
        POP_LO   = 3'd3,
        POP_HI   = 3'd4,
        POP_WAIT = 3'd5,
        DONE     = 3'd6
    } cs_state_e;

endpackage

// File: rtl/stack_depth_ctr.sv
// Saturating up/down entry counter with full/empty flags for overflow/underflow checks.
module stack_depth_ctr #(
    parameter int DEPTH_W   = 5,
    parameter int MAX_DEPTH = 16
) (
    input  logic               W_Clk,
    input  logic               Reset_n,
    input  logic               inc,
    input  logic               dec,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    assign full  = (depth == DEPTH_W'(MAX_DEPTH));
    assign empty = (depth == '0);

    always_ff @(posedge W_Clk or negedge Reset_n) begin
        if (!Reset_n)
            depth <= '0;
        else if (inc && !dec && !full)
            depth <= depth + 1'b1;
        else if (dec && !inc && !empty)
            depth <= depth - 1'b1;
    end

endmodule

// File: rtl/call_stack_ctrl.sv
// CALL/RET return-address stack responder: 64-bit entries stored as word pairs in 32-bit memory.
// Optional top-of-stack shadow for single-cycle returns: define RAS_BYPASS_EN.
module call_stack_ctrl
    import robonaut_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] SP_TOP    = ADDR_W'(SP_TOP_DEFAULT),
    parameter int                MAX_DEPTH = 16
) (
    input  logic              W_Clk,
    input  logic              Reset_n,
    input  logic              Push_Req,
    input  logic              Pop_Req,
    input  logic [RA_W-1:0]   Push_Data,
    input  logic [ADDR_W-1:0] SP_In,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [WORD_W-1:0] Mem_WData,
    output logic              Mem_WE,
    output logic              Mem_RE,
    input  logic [WORD_W-1:0] Mem_RData,
    output logic [WORD_W-1:0] RdBuf1Wire,
    output logic [WORD_W-1:0] RdBuf0Wire,
    output logic              Busy,
    output logic              Done,
    output logic [4:0]        Depth,
    output logic              Ovf,
    output logic              Unf
);

    cs_state_e         state_q, state_d;
    logic [ADDR_W-1:0] sp_q;
    logic [RA_W-1:0]   data_q;
    logic              acc_push, acc_pop, cap0, cap1, inc, dec, set_ovf, set_unf;
    logic              full, empty;
`ifdef RAS_BYPASS_EN
    logic [RA_W-1:0]   shadow_q;
    logic              shadow_vld_q;
    logic              byp_pop;
`endif

    stack_depth_ctr #(.DEPTH_W(5), .MAX_DEPTH(MAX_DEPTH)) u_depth (
        .W_Clk   (W_Clk),
        .Reset_n (Reset_n),
        .inc     (inc),
        .dec     (dec),
        .depth   (Depth),
        .full    (full),
        .empty   (empty)
    );

    assign Busy = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        acc_push  = 1'b0;
        acc_pop   = 1'b0;
        cap0      = 1'b0;
        cap1      = 1'b0;
        inc       = 1'b0;
        dec       = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        Mem_Addr  = '0;
        Mem_WData = '0;
        Mem_WE    = 1'b0;
        Mem_RE    = 1'b0;
        Done      = 1'b0;
`ifdef RAS_BYPASS_EN
        byp_pop   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                // push has priority; a simultaneous pop is simply dropped
                if (Push_Req) begin
                    if (full) set_ovf = 1'b1;
                    else begin
                        acc_push = 1'b1;
                        state_d  = PUSH_LO;
                    end
                end else if (Pop_Req) begin
                    if (empty) set_unf = 1'b1;
`ifdef RAS_BYPASS_EN
                    else if (shadow_vld_q) begin
                        byp_pop = 1'b1;
                        dec     = 1'b1;
                        state_d = DONE;
                    end
`endif
                    else begin
                        acc_pop = 1'b1;
                        state_d = POP_LO;
                    end
                end
            end
            PUSH_LO: begin
                Mem_WE    = 1'b1;
                Mem_Addr  = sp_q;
                Mem_WData = data_q[WORD_W-1:0];
                state_d   = PUSH_HI;
            end
            PUSH_HI: begin
                Mem_WE    = 1'b1;
                Mem_Addr  = sp_q + ADDR_W'(1);
                Mem_WData = data_q[RA_W-1:WORD_W];
                inc       = 1'b1;
                state_d   = DONE;
            end
            POP_LO: begin
                Mem_RE   = 1'b1;
                Mem_Addr = sp_q + ADDR_W'(2);
                state_d  = POP_HI;
            end
            POP_HI: begin
                // read data lags the strobe by one cycle: this is the low word
                Mem_RE   = 1'b1;
                Mem_Addr = sp_q + ADDR_W'(3);
                cap0     = 1'b1;
                state_d  = POP_WAIT;
            end
            POP_WAIT: begin
                cap1    = 1'b1;
                dec     = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge W_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            sp_q       <= SP_TOP;
            data_q     <= '0;
            RdBuf0Wire <= '0;
            RdBuf1Wire <= '0;
            Ovf        <= 1'b0;
            Unf        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (acc_push) begin
                sp_q   <= SP_In;
                data_q <= Push_Data;
            end
            if (acc_pop) sp_q <= SP_In;
            if (cap0)    RdBuf0Wire <= Mem_RData;
            if (cap1)    RdBuf1Wire <= Mem_RData;
`ifdef RAS_BYPASS_EN
            if (byp_pop) {RdBuf1Wire, RdBuf0Wire} <= shadow_q;
`endif
            if (set_ovf) Ovf <= 1'b1;
            if (set_unf) Unf <= 1'b1;
        end
    end

`ifdef RAS_BYPASS_EN
    always_ff @(posedge W_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shadow_q     <= '0;
            shadow_vld_q <= 1'b0;
        end else if (acc_push) begin
            shadow_q     <= Push_Data;
            shadow_vld_q <= 1'b1;
        end else if (byp_pop) begin
            shadow_vld_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed self-checking bench for call_stack_ctrl with a one-cycle-latency word memory model.
module tb_call_stack_ctrl;

    logic        W_Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Push_Req = 1'b0, Pop_Req = 1'b0;
    logic [63:0] Push_Data = '0;
    logic [9:0]  SP_In = '0;
    logic [9:0]  Mem_Addr;
    logic [31:0] Mem_WData, Mem_RData, RdBuf1Wire, RdBuf0Wire;
    logic        Mem_WE, Mem_RE, Busy, Done, Ovf, Unf;
    logic [4:0]  Depth;

    logic [31:0] mem [0:1023];
    int checks = 0, errors = 0;
    int we_cnt = 0, re_cnt = 0, done_cnt = 0, both_cnt = 0;
    int base_we, base_re, base_done;

    call_stack_ctrl dut (
        .W_Clk(W_Clk), .Reset_n(Reset_n), .Push_Req(Push_Req), .Pop_Req(Pop_Req),
        .Push_Data(Push_Data), .SP_In(SP_In), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
        .Mem_WE(Mem_WE), .Mem_RE(Mem_RE), .Mem_RData(Mem_RData), .RdBuf1Wire(RdBuf1Wire),
        .RdBuf0Wire(RdBuf0Wire), .Busy(Busy), .Done(Done), .Depth(Depth), .Ovf(Ovf), .Unf(Unf)
    );

    always #5 W_Clk = ~W_Clk;

    always @(posedge W_Clk) begin
        if (Mem_WE) mem[Mem_Addr] <= Mem_WData;
        if (Mem_RE) Mem_RData <= mem[Mem_Addr];
        if (Mem_WE) we_cnt++;
        if (Mem_RE) re_cnt++;
        if (Done) done_cnt++;
        if (Mem_WE && Mem_RE) both_cnt++;
    end

    task automatic tick();
        @(posedge W_Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [9:0] sp, input logic [63:0] d);
        Push_Req = 1'b1; SP_In = sp; Push_Data = d;
        tick();
        Push_Req = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic pop_wait(input logic [9:0] sp, input string tag);
        int n;
        Pop_Req = 1'b1; SP_In = sp;
        tick();
        Pop_Req = 1'b0;
        n = 0;
        while (!Done && n < 10) begin tick(); n++; end
        check({tag, "_done"}, Done, 1);
        tick();
    endtask

    initial begin
        Mem_RData = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // reset state
        #1;
        check("rst_addr", Mem_Addr, 0);
        check("rst_we_re", {Mem_WE, Mem_RE, Busy, Done, Ovf, Unf}, 0);
        check("rst_depth", Depth, 0);
        check("rst_rdbuf", {RdBuf1Wire, RdBuf0Wire}, 0);
        tick();
        Reset_n = 1'b1;
        tick();

        // first push
        Push_Req = 1'b1; Push_Data = 64'h0000_0001_0000_0042; SP_In = 10'h3F9;
        tick();
        Push_Req = 1'b0;
        check("p1_lo", {Mem_WE, Mem_RE, Busy}, 3'b101);
        check("p1_lo_addr", Mem_Addr, 10'h3F9);
        check("p1_lo_data", Mem_WData, 32'h42);
        tick();
        check("p1_hi_addr", Mem_Addr, 10'h3FA);
        check("p1_hi_data", Mem_WData, 32'h1);
        check("p1_hi_depth", Depth, 0);
        tick();
        check("p1_done", {Done, Mem_WE, Mem_Addr}, {1'b1, 1'b0, 10'h0});
        check("p1_depth", Depth, 1);
        tick();
        check("p1_idle", {Done, Busy}, 0);
        check("p1_mem", {mem[10'h3FA], mem[10'h3F9]}, 64'h0000_0001_0000_0042);

        // pop it back
        base_re = re_cnt;
        Pop_Req = 1'b1; SP_In = 10'h3F7;
        tick();
        Pop_Req = 1'b0;
`ifdef RAS_BYPASS_EN
        check("byp_done", Done, 1);
        check("byp_no_re", re_cnt - base_re, 0);
`else
        check("pop_lo", {Mem_RE, Mem_WE, Mem_Addr}, {1'b1, 1'b0, 10'h3F9});
        tick();
        check("pop_hi", {Mem_RE, Mem_Addr}, {1'b1, 10'h3FA});
        tick();
        check("pop_wait_buf0", {Mem_RE, RdBuf0Wire}, {1'b0, 32'h42});
        tick();
        check("pop_done", Done, 1);
`endif
        check("pop_buf", {RdBuf1Wire, RdBuf0Wire}, 64'h0000_0001_0000_0042);
        check("pop_depth", Depth, 0);
        tick();

        // underflow
        base_re = re_cnt; base_done = done_cnt;
        Pop_Req = 1'b1; SP_In = 10'h3F5;
        tick();
        Pop_Req = 1'b0;
        check("unf_busy", Busy, 0);
        tick(); tick();
        check("unf_flag", {Unf, Ovf}, 2'b10);
        check("unf_no_re", re_cnt - base_re, 0);
        check("unf_no_done", done_cnt - base_done, 0);
        check("unf_buf", {RdBuf1Wire, RdBuf0Wire}, 64'h0000_0001_0000_0042);

        // fill to MAX_DEPTH, then one more
        for (int i = 0; i < 16; i++)
            push(10'h3F9 - 10'(2 * i), {32'(i + 1), 32'(i + 100)});
        check("full_depth", Depth, 16);
        check("full_no_ovf", Ovf, 0);
        base_we = we_cnt; base_done = done_cnt;
        Push_Req = 1'b1; SP_In = 10'h3D7; Push_Data = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        Push_Req = 1'b0;
        check("ovf_busy", Busy, 0);
        tick(); tick();
        check("ovf_flag", Ovf, 1);
        check("ovf_no_we", we_cnt - base_we, 0);
        check("ovf_no_done", done_cnt - base_done, 0);
        check("ovf_depth", Depth, 16);

        // pop top entry (16th push, SP 0x3DB)
        pop_wait(10'h3D9, "top");
        check("top_buf", {RdBuf1Wire, RdBuf0Wire}, {32'd16, 32'd115});
        check("top_depth", Depth, 15);

        // reset while in POP_HI
        Pop_Req = 1'b1; SP_In = 10'h3D7;
        tick();
        Pop_Req = 1'b0;
        tick();
        check("mid_pop_hi", {Mem_RE, Mem_Addr}, {1'b1, 10'h3DA});
        Reset_n = 1'b0;
        #1;
        check("mid_rst_mem", {Mem_WE, Mem_RE, Mem_Addr, Mem_WData}, 0);
        check("mid_rst_flags", {Busy, Done, Ovf, Unf, Depth}, 0);
        check("mid_rst_buf", {RdBuf1Wire, RdBuf0Wire}, 0);
        tick();
        Reset_n = 1'b1;
        tick();

        // push after reset behaves as the first one
        Push_Req = 1'b1; Push_Data = 64'h0000_0001_0000_0042; SP_In = 10'h3F9;
        tick();
        Push_Req = 1'b0;
        check("rp_lo", {Mem_WE, Mem_Addr, Mem_WData}, {1'b1, 10'h3F9, 32'h42});
        tick();
        check("rp_hi", {Mem_WE, Mem_Addr, Mem_WData}, {1'b1, 10'h3FA, 32'h1});
        tick();
        check("rp_done", {Done, Depth}, {1'b1, 5'd1});
        tick();

        // simultaneous push/pop at depth 0, plus a pop pulse during PUSH_HI
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
        base_re = re_cnt;
        Push_Req = 1'b1; Pop_Req = 1'b1; SP_In = 10'h3F9; Push_Data = 64'h1234_5678_9ABC_DEF0;
        tick();
        Push_Req = 1'b0; Pop_Req = 1'b0;
        check("both_push_lo", {Mem_WE, Mem_WData}, {1'b1, 32'h9ABC_DEF0});
        tick();
        Pop_Req = 1'b1;
        tick();
        Pop_Req = 1'b0;
        check("both_done", {Done, Unf, Depth}, {1'b1, 1'b0, 5'd1});
        tick();
        check("both_idle", {Busy, Unf, Depth}, {1'b0, 1'b0, 5'd1});
        check("both_no_re", re_cnt - base_re, 0);

`ifdef RAS_BYPASS_EN
        // push then bypassed pop
        push(10'h3F7, 64'hAAAA_0001_BBBB_0002);
        base_re = re_cnt;
        Pop_Req = 1'b1; SP_In = 10'h3F5;
        tick();
        Pop_Req = 1'b0;
        check("byp2_done", Done, 1);
        check("byp2_buf", {RdBuf1Wire, RdBuf0Wire}, 64'hAAAA_0001_BBBB_0002);
        check("byp2_no_re", re_cnt - base_re, 0);
        tick();
`endif

        check("we_re_exclusive", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
